instr_fetch: RTL

Instruction fetch unit for the RISC-V core. Holds the architectural PC and issues one instruction-memory read at a time with a request/grant/response handshake. Presents each fetched word to decode through a valid/ready output buffer. Redirects the PC when the branch logic resolves a taken branch or jump, discarding wrong-path fetches.

---
 rtl/instr_fetch_pkg.sv | 21 ++
 rtl/instr_fetch_if.sv | 35 +++
 rtl/instr_fetch.sv | 124 ++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared fetch definitions: state encoding, instruction size, reset PC and NOP.
// Imported by the fetch unit and by downstream decode logic.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  // 32-bit wrap from 32'hFFFF_FFFC to 0 is intentional
  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch unit bus bundle: branch redirect, instruction-memory handshake and
// the valid/ready instruction output toward decode.
interface instr_fetch_if;

  logic        redirect;
  logic [31:0] redirect_pc;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    input  redirect, redirect_pc,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  instr_ready,
    output imem_req, imem_addr,
    output instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect, redirect_pc,
    output imem_gnt, imem_rvalid, imem_rdata,
    output instr_ready,
    input  imem_req, imem_addr,
    input  instr_valid, instr, instr_pc
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding imem read, single-entry output buffer,
// PC redirect with squash of wrong-path responses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | just out of reset, request starts next cycle
// ST_REQ  | imem_req high, waiting for grant at imem_addr = pc
// ST_WAIT | request granted, waiting for rvalid (discard set = wrong path)
// ST_HOLD | instruction buffered, waiting for decode to take it
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         valid_q, valid_d;
  logic         discard_q, discard_d;
  logic [31:0]  target_pc;
  logic         unused_pc_lsb;

  assign target_pc     = {bus.redirect_pc[31:2], 2'b00};
  assign unused_pc_lsb = ^bus.redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      discard_q  <= discard_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    discard_d  = discard_q;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (bus.imem_gnt) begin
          state_d   = ST_WAIT;
          discard_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = ST_REQ;
          end else begin
            instr_d    = bus.imem_rdata;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_incr(pc_q);
            state_d    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.instr_ready) begin
          valid_d = 1'b0;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Redirect wins over the normal transitions; buffer contents are left as-is
    // but no longer valid, and any granted-but-unreturned read becomes wrong-path.
    if (bus.redirect && (state_q != ST_IDLE)) begin
      pc_d       = target_pc;
      valid_d    = 1'b0;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      case (state_q)
        ST_REQ: begin
          if (bus.imem_gnt) begin
            state_d   = ST_WAIT;
            discard_d = 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rvalid) begin
            state_d   = ST_REQ;
            discard_d = 1'b0;
          end else begin
            state_d   = ST_WAIT;
            discard_d = 1'b1;
          end
        end
        ST_HOLD: state_d = ST_REQ;
        default: state_d = state_q;
      endcase
    end
  end

  assign bus.imem_req    = (state_q == ST_REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule
